four_bank_mem_resp: RTL and testbench
=====================================

# four_bank_mem_resp

Responder side of the cache-to-main-memory interface: a four-way interleaved, word-addressed 16-bit memory that accepts one read or write per cycle from the cache controller. It reports per-bank occupancy on `busy`, returns read data at fixed latency, and flags illegal requests on `err`. It sits directly below the cache FSM and is the only path to backing storage.

## Interface
- `WORDS_PER_BANK`, 8192: words stored in each bank, for 64 KB total.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in 16: byte address. `addr[2:1]` selects the bank, `addr[15:3]` selects the word within the bank, and `addr[0]` must be 0.
- `data_in` in 16: write data, sampled in the acceptance cycle.
- `wr` in 1: write request, level-sampled each cycle.
- `rd` in 1: read request, level-sampled each cycle.
- `data_out` out 16: read data, valid only in its return cycle and 0 otherwise.
- `busy` out 4: bit b high while bank b is occupied.
- `err` out 1: one-cycle pulse marking a rejected request.

## Operation
- A request in cycle T means `rd ^ wr` is high at the rising edge ending T.
- It is accepted when `busy[bank]` is 0 in cycle T and the address is legal.
- An accepted write commits `data_in` to the array at the end of T. A read of the same word in T+1 or later returns the new value.
- An accepted read latches the word at the end of T. `data_out` presents it in cycle T+2 only.
- On acceptance, `busy[bank]` goes high for cycles T+1, T+2 and T+3, then drops in T+4. The bank can accept again in T+4. Each bank uses a 2-bit down-counter loaded with 3.
- Other banks remain independently accessible, so back-to-back requests to banks 0,1,2,3 are accepted on consecutive cycles.
- At most one request is accepted per cycle, so at most one read returns per cycle and there is no `data_out` collision.
- Rejections all raise `err` in cycle T+1 for one cycle. The array and `busy` are left unchanged, and the requester must retry. Rejected cases:
  - `rd & wr` both high;
  - target bank busy;
  - `addr[0]=1`, when `UNALIGNED_ERR_EN` is defined.
- Idle cycles (`rd=wr=0`) do nothing.
- Array contents are not affected by `rst`. Words never written read as 0, because the array is zero-initialised at time 0.

## Timing
- Reset values:
  - `data_out=0`, `busy=4'b0000`, `err=0`;
  - all bank counters 0;
  - the read-return pipeline is cleared.
- Read latency is 2 cycles, from acceptance to `data_out`.
- Bank occupancy is 4 cycles including the acceptance cycle.
- `busy` and `err` are registered outputs, with no combinational path from inputs.
- `rst` asserted mid-operation:
  - in-flight reads are discarded, so no `data_out` appears after `rst` releases;
  - writes accepted before `rst` remain committed;
  - `busy` clears immediately on `rst` assertion (asynchronous).
- A request in the first cycle after `rst` deasserts is accepted normally.

## Configuration
- `UNALIGNED_ERR_EN` defined: `addr[0]=1` rejects the request with an `err` pulse.
- `UNALIGNED_ERR_EN` not defined: `addr[0]` is ignored and the request is treated as aligned.

## Structure
- Shared package `mem_pkg` holds:
  - `BANK_BUSY_CYCLES=3` and `READ_LAT=2`;
  - the bank-select field position (`addr[2:1]`);
  - the word-index field position (`addr[15:3]`).
- The cache FSM uses the same constants.
- One sub-module, `mem_bank`, instantiated ×4. Each instance holds one bank's storage array, busy counter and read-data register.
- The top level holds:
  - bank decode;
  - legality check and error register;
  - a 2-stage valid/bank pipeline that muxes the returning bank onto `data_out`.

## Test plan
- Write then read: write 0xBEEF to 0x0010 (bank 0). In T+1 through T+3, `busy=0001`. Read 0x0010 in T+4, and `data_out=0xBEEF` two cycles later, 0 in all other cycles.
- Interleave: write 0x1111/0x2222/0x3333/0x4444 to 0x0000/0x0002/0x0004/0x0006 on consecutive cycles. `busy` steps 0001, 0011, 0111, 1111, then clears in the same order. Reads of the four addresses return in order at 2-cycle latency.
- Bank conflict: read 0x0020, then read 0x0028 (same bank) one cycle later. The second request gets an `err` pulse, `busy[0]` keeps its original timing, and only the first read's data appears.
- Illegal request:
  - `rd=wr=1` at 0x0040 gives an `err` pulse and no write occurs;
  - with `UNALIGNED_ERR_EN`, a write to 0x0041 gives an `err` pulse and 0x0040 still reads 0;
  - without the macro, a write of 0x5A5A to 0x0041 succeeds and 0x0040 then reads 0x5A5A.
- Reset mid-read: read 0x0010, then assert `rst` in T+1. `busy` clears immediately and `data_out` stays 0. After release, a read of 0x0010 returns the previously written value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and request type for the four-bank main-memory responder.
// Also used by the cache FSM, so field positions live here rather than in the top.
package mem_pkg;
    localparam int NUM_BANKS        = 4;
    localparam int DATA_W           = 16;
    localparam int ADDR_W           = 16;
    localparam int BANK_BUSY_CYCLES = 3;
    localparam int READ_LAT         = 2;

    // addr[2:1] selects the bank, addr[15:3] the word within it
    localparam int BANK_LSB = 1;
    localparam int BANK_W   = 2;
    localparam int WIDX_LSB = 3;
    localparam int WIDX_W   = 13;

    typedef struct packed {
        logic              we;
        logic [WIDX_W-1:0] idx;
        logic [DATA_W-1:0] wdata;
    } bank_req_t;
endpackage

// File: rtl/mem_bank.sv
// One memory bank: word storage, occupancy down-counter and read-data register.
// Storage is zero at time 0 and is deliberately untouched by rst.
module mem_bank
    import mem_pkg::*;
#(
    parameter int WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  bank_req_t         req,
    output logic              busy,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};
    logic [1:0]        cnt;

    always_ff @(posedge clk) begin
        if (sel) begin
            if (req.we)
                mem[req.idx] <= req.wdata;
            else
                rdata <= mem[req.idx];
        end
    end

    // Loaded on acceptance; busy covers the three cycles after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (sel)
            cnt <= 2'(BANK_BUSY_CYCLES);
        else if (cnt != 2'd0)
            cnt <= cnt - 2'd1;
    end

    assign busy = |cnt;
endmodule

// File: rtl/four_bank_mem_resp.sv
// Four-way interleaved 16-bit memory responder: bank decode, legality/err, read-return pipe.
// Define UNALIGNED_ERR_EN to reject requests with addr[0]=1.
module four_bank_mem_resp
    import mem_pkg::*;
#(
    parameter int WORDS_PER_BANK = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic [3:0]  busy,
    output logic        err
);
    localparam int STAGES = READ_LAT - 1;

    logic [BANK_W-1:0]                   bank;
    logic                                req_vld;
    logic                                misalign;
    logic                                accept;
    logic                                reject;
    logic [NUM_BANKS-1:0]                sel;
    logic [NUM_BANKS-1:0][DATA_W-1:0]    rdata;
    bank_req_t                           breq;
    logic [STAGES:1]                     vld_pipe;
    logic [STAGES:1][BANK_W-1:0]         bank_pipe;

    assign bank = addr[BANK_LSB +: BANK_W];

`ifdef UNALIGNED_ERR_EN
    assign misalign = addr[0];
`else
    logic unused_addr0;
    assign unused_addr0 = addr[0];
    assign misalign     = 1'b0;
`endif

    assign req_vld = rd ^ wr;
    assign accept  = req_vld & ~busy[bank] & ~misalign;
    assign reject  = (rd & wr) | (req_vld & (busy[bank] | misalign));
    assign breq    = '{we: wr, idx: addr[WIDX_LSB +: WIDX_W], wdata: data_in};

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign sel[b] = accept & (bank == BANK_W'(b));
            mem_bank #(.WORDS(WORDS_PER_BANK)) u_bank (
                .clk   (clk),
                .rst   (rst),
                .sel   (sel[b]),
                .req   (breq),
                .busy  (busy[b]),
                .rdata (rdata[b])
            );
        end
    endgenerate

    // Bank data is latched at acceptance; the pipe tags which bank returns and when
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            vld_pipe  <= '0;
            bank_pipe <= '0;
            data_out  <= '0;
        end else begin
            err          <= reject;
            vld_pipe[1]  <= accept & rd;
            bank_pipe[1] <= bank;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                bank_pipe[s] <= bank_pipe[s-1];
            end
            data_out <= vld_pipe[STAGES] ? rdata[bank_pipe[STAGES]] : '0;
        end
    end
endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Directed bench: stimulus pushes expected read returns and err pulses; a monitor checks every cycle.
module tb_four_bank_mem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, data_in, data_out;
    logic        wr, rd, err;
    logic [3:0]  busy;

    typedef struct { int cyc; logic [15:0] d; } exp_t;
    exp_t q_rd[$];
    int   q_err[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    four_bank_mem_resp dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .wr(wr), .rd(rd), .data_out(data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!done) begin
            exp_t e;
            total++;
            if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
                e = q_rd.pop_front();
                if (data_out !== e.d) begin
                    bad++;
                    $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, data_out, e.d);
                end
            end else if (data_out !== 16'h0) begin
                bad++;
                $display("FAIL idle_dout cyc=%0d got=%h want=0000", cyc, data_out);
            end
            total++;
            if (q_err.size() > 0 && q_err[0] == cyc) begin
                void'(q_err.pop_front());
                if (err !== 1'b1) begin
                    bad++;
                    $display("FAIL err_pulse cyc=%0d got=%b want=1", cyc, err);
                end
            end else if (err !== 1'b0) begin
                bad++;
                $display("FAIL err_idle cyc=%0d got=%b want=0", cyc, err);
            end
        end
    end

    task automatic check_busy(input logic [3:0] eb, input string nm);
        total++;
        if (busy !== eb) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, busy, eb);
        end
    endtask

    // Drive one cycle; eb is busy expected in this cycle, ed the read data expected two cycles on
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] eb, input logic rej, input logic [15:0] ed, input logic keep);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; data_in = d;
        check_busy(eb, "busy");
        if (rej)
            q_err.push_back(cyc + 1);
        else if (r && !w && keep)
            q_rd.push_back('{cyc + 2, ed});
    endtask

    task automatic idle(input logic [3:0] eb);
        step(1'b0, 1'b0, 16'h0, 16'h0, eb, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        #2;
        total += 3;
        if (busy !== 4'b0000)   begin bad++; $display("FAIL reset_busy got=%b want=0000", busy); end
        if (data_out !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0000", data_out); end
        if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // write then read, bank 0
        step(0, 1, 16'h0010, 16'hBEEF, 4'b0000, 0, 0, 1);
        repeat (3) idle(4'b0001);
        step(1, 0, 16'h0010, 16'h0, 4'b0000, 0, 16'hBEEF, 1);
        repeat (3) idle(4'b0001);
        idle(4'b0000);

        // interleave across all four banks
        step(0, 1, 16'h0000, 16'h1111, 4'b0000, 0, 0, 1);
        step(0, 1, 16'h0002, 16'h2222, 4'b0001, 0, 0, 1);
        step(0, 1, 16'h0004, 16'h3333, 4'b0011, 0, 0, 1);
        step(0, 1, 16'h0006, 16'h4444, 4'b0111, 0, 0, 1);
        idle(4'b1110); idle(4'b1100); idle(4'b1000);
        step(1, 0, 16'h0000, 16'h0, 4'b0000, 0, 16'h1111, 1);
        step(1, 0, 16'h0002, 16'h0, 4'b0001, 0, 16'h2222, 1);
        step(1, 0, 16'h0004, 16'h0, 4'b0011, 0, 16'h3333, 1);
        step(1, 0, 16'h0006, 16'h0, 4'b0111, 0, 16'h4444, 1);
        idle(4'b1110); idle(4'b1100); idle(4'b1000);

        // bank conflict: second read to bank 0 rejected, timing of first unchanged
        step(0, 1, 16'h0020, 16'hCAFE, 4'b0000, 0, 0, 1);
        repeat (3) idle(4'b0001);
        step(0, 1, 16'h0028, 16'hD00D, 4'b0000, 0, 0, 1);
        repeat (3) idle(4'b0001);
        step(1, 0, 16'h0020, 16'h0, 4'b0000, 0, 16'hCAFE, 1);
        step(1, 0, 16'h0028, 16'h0, 4'b0001, 1, 0, 1);
        idle(4'b0001); idle(4'b0001);

        // rd&wr together: rejected, nothing written
        step(1, 1, 16'h0040, 16'h7777, 4'b0000, 1, 0, 1);
        idle(4'b0000);
        step(1, 0, 16'h0040, 16'h0, 4'b0000, 0, 16'h0000, 1);
        repeat (3) idle(4'b0001);
`ifdef UNALIGNED_ERR_EN
        step(0, 1, 16'h0041, 16'h5A5A, 4'b0000, 1, 0, 1);
        idle(4'b0000);
        step(1, 0, 16'h0040, 16'h0, 4'b0000, 0, 16'h0000, 1);
`else
        step(0, 1, 16'h0041, 16'h5A5A, 4'b0000, 0, 0, 1);
        repeat (3) idle(4'b0001);
        step(1, 0, 16'h0040, 16'h0, 4'b0000, 0, 16'h5A5A, 1);
`endif
        repeat (3) idle(4'b0001);

        // reset mid-read: in-flight data dropped, array kept
        step(1, 0, 16'h0010, 16'h0, 4'b0000, 0, 0, 0);
        @(posedge clk); #1;
        rd = 1'b0; rst = 1'b1;
        #1;
        check_busy(4'b0000, "rst_busy");
        total++;
        if (data_out !== 16'h0) begin bad++; $display("FAIL rst_dout got=%h want=0000", data_out); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rd = 1'b1; addr = 16'h0010;
        check_busy(4'b0000, "post_rst_busy");
        q_rd.push_back('{cyc + 2, 16'hBEEF});
        repeat (3) idle(4'b0001);
        repeat (2) idle(4'b0000);

        @(posedge clk); #1;
        done = 1;
        total += 2;
        if (q_rd.size() != 0)  begin bad++; $display("FAIL rd_drain left=%0d want=0", q_rd.size()); end
        if (q_err.size() != 0) begin bad++; $display("FAIL err_drain left=%0d want=0", q_err.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
